// File: rtl/mac_seq_pkg.sv
// Shared FSM encoding and default widths for the dot-product sequencer.
package mac_seq_pkg;

    localparam int NBITS_DEF = 8;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_seq_mac.sv
// Free-running multiply-accumulate: one product per cycle, clear reloads with the current product.
// Result visible one cycle after the operands; no backpressure, zero operands hold the sum.
module mac_seq_mac #(
    parameter int Nbits = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [Nbits-1:0]   a,
    input  logic [Nbits-1:0]   b,
    output logic [2*Nbits-1:0] acc
);

    logic [2*Nbits-1:0] prod;

    // Zero-extend both operands so the product is computed at full width.
    assign prod = {{Nbits{1'b0}}, a} * {{Nbits{1'b0}}, b};

    // Deliberately no reset: the sequencer always clears before a result is used.
    always_ff @(posedge clk) begin
        if (clear) begin
            acc <= prod;
        end else begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/mac_seq.sv
// Dot-product job sequencer around one MAC; result valid 1 cycle after the last transfer.
// in_ready is high only while running; a finished result is held until res_ready.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int Nbits = NBITS_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Nbits-1:0]   a_data,
    input  logic [Nbits-1:0]   b_data,
    output logic [2*Nbits-1:0] res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_nxt;
    logic             xfer;
    logic             mac_clear;
    logic [Nbits-1:0] mac_a;
    logic [Nbits-1:0] mac_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            len_q <= len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        xfer      = 1'b0;
        mac_clear = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_nxt   = len;
                        cnt_nxt   = '0;
                        state_nxt = S_RUN;
                    end else begin
                        // Empty job: clear with zero operands so the result reads 0.
                        mac_clear = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_RUN: begin
                in_ready  = 1'b1;
                xfer      = in_valid;
                // Clearing on every stalled first cycle keeps stale sums out.
                mac_clear = (cnt == '0);
                if (xfer) begin
                    mac_a   = a_data;
                    mac_b   = b_data;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == len_q - 1'b1) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    mac_seq_mac #(
        .Nbits (Nbits)
    ) u_mac (
        .clk   (clk),
        .clear (mac_clear),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (res_data)
    );

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: transaction-level dot-product model plus cycle-level protocol checks.
module tb_mac_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_data;
    logic [7:0]  b_data;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int          ja[$];
    int          jb[$];
    logic [15:0] model_res = '0;
    bit          model_armed = 1'b0;

    mac_seq #(.Nbits(8), .LEN_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_data    (a_data),
        .b_data    (b_data),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Dot product of the current job's vectors, wrapped to 16 bits.
    function automatic logic [15:0] model_dot();
        longint s = 0;
        foreach (ja[i]) s += longint'(ja[i]) * longint'(jb[i]);
        return 16'(s % 65536);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from ja/jb; gap = idle cycles between elements,
    // hold = cycles res_ready stays low in DONE (start pulsed meanwhile).
    task automatic run_job(input int n, input int gap, input int hold, input logic [15:0] lit);
        model_res   = model_dot();
        model_armed = 1'b1;
        check("model_pin", model_res, lit);
        res_ready = (hold == 0);
        start     = 1'b1;
        len       = 8'(n);
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        next_cycle();
        start = 1'b0;
        len   = '0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            a_data   = 8'(ja[i]);
            b_data   = 8'(jb[i]);
            @(negedge clk);
            check("run_in_ready", in_ready, 1);
            check("run_res_valid", res_valid, 0);
            next_cycle();
            if (gap > 0 && i < n - 1) begin
                in_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_in_ready", in_ready, 1);
                    next_cycle();
                end
            end
        end
        in_valid = 1'b0;
        a_data   = '0;
        b_data   = '0;
        @(negedge clk);
        check("res_valid_latency", res_valid, 1);
        check("res_data", res_data, lit);
        check("done_busy", busy, 1);
        if (hold > 0) begin
            for (int k = 1; k < hold; k++) begin
                next_cycle();
                start = (k == 1 || k == 2);
                len   = 8'd2;
                @(negedge clk);
                check("hold_res_valid", res_valid, 1);
                check("hold_res_data", res_data, lit);
                check("hold_in_ready", in_ready, 0);
            end
            next_cycle();
            start     = 1'b0;
            len       = '0;
            res_ready = 1'b1;
            @(negedge clk);
            check("accept_res_valid", res_valid, 1);
            check("accept_res_data", res_data, lit);
        end
        next_cycle();
        res_ready = 1'b0;
        @(negedge clk);
        check("post_busy", busy, 0);
        check("post_res_valid", res_valid, 0);
        check("post_in_ready", in_ready, 0);
        next_cycle();
    endtask

    // Cycle-by-cycle comparison against the transaction model and protocol rules.
    always @(negedge clk) begin
        if (!reset) begin
            if (res_valid && model_armed) check("model_cmp", res_data, model_res);
            check("ready_valid_excl", in_ready & res_valid, 0);
            if (in_ready || res_valid) check("busy_cmp", busy, 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        a_data    = '0;
        b_data    = '0;
        res_ready = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_busy", busy, 0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        ja = '{1, 2, 3};    jb = '{4, 5, 6};
        run_job(3, 0, 0, 16'd32);
        run_job(3, 2, 0, 16'd32);

        ja = '{255, 255};   jb = '{255, 255};
        run_job(2, 0, 0, 16'd64514);

        ja = {};            jb = {};
        run_job(0, 0, 0, 16'd0);

        ja = '{9};          jb = '{9};
        run_job(1, 0, 0, 16'd81);

        ja = '{10, 20};     jb = '{30, 40};
        run_job(2, 0, 5, 16'd1100);

        // Abandon a 4-element job after two transfers.
        model_armed = 1'b0;
        start = 1'b1;
        len   = 8'd4;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a_data   = 8'(i + 5);
            b_data   = 8'(i + 6);
            next_cycle();
        end
        reset = 1'b1;
        #1;
        check("midreset_in_ready", in_ready, 0);
        check("midreset_busy", busy, 0);
        check("midreset_res_valid", res_valid, 0);
        in_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
        next_cycle();

        ja = '{3};          jb = '{7};
        run_job(1, 0, 0, 16'd21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
